imem_read_arbiter: RTL and testbench
====================================

Name: imem_read_arbiter

Overview:
- Shares the single read port of the synchronous instruction memory between two requesters: instruction fetch (IF) and the load/store unit (LS), which reads constants and data from the instruction-memory region.
- Arbitrates one request per cycle, issues a word address to the memory, and routes the one-cycle-late read data back to the requester that was granted.
- Sits between the fetch stage, the LSU and the instruction memory.

Parameters:
- STARVE_MAX, 4: number of consecutive cycles IF may be denied while valid before it is forced to win.
- CNT_W, 3: width of the starvation counter; must satisfy 2**CNT_W > STARVE_MAX.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- if_req_valid  input  1  fetch request present
- if_req_addr  input  32  fetch byte address
- if_req_ready  output  1  fetch request accepted this cycle
- if_flush  input  1  kill any fetch response due next cycle
- if_rsp_valid  output  1  fetch response valid (one-cycle pulse)
- if_rsp_data  output  32  fetch instruction word
- if_rsp_err  output  1  fetch address was misaligned
- ls_req_valid  input  1  LSU request present
- ls_req_addr  input  32  LSU byte address
- ls_req_ready  output  1  LSU request accepted this cycle
- ls_rsp_valid  output  1  LSU response valid (one-cycle pulse)
- ls_rsp_data  output  32  LSU read word
- ls_rsp_err  output  1  LSU address was misaligned
- mem_en  output  1  memory read enable
- mem_addr  output  30  word address, equal to byte address bits [31:2]
- mem_rdata  input  32  memory data, valid the cycle after mem_en

Behaviour:
- Reset (async, rst=1): starvation counter = 0; response-owner register = NONE; err flag = 0. All outputs are 0 while rst is high: readies, rsp_valid, rsp_err, rsp_data, mem_en, mem_addr.
- A response owed from a request granted before reset is dropped. No response is issued after reset deasserts.
- Grant (combinational, same cycle):
  - LS wins when ls_req_valid=1, unless the starvation counter equals STARVE_MAX and if_req_valid=1; in that case IF wins.
  - Otherwise IF wins when if_req_valid=1.
  - At most one ready is high per cycle. ready is high only when the matching valid is high.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, when if_req_valid=1 and IF is not granted.
  - Clears when IF is granted or when if_req_valid=0.
- Issue:
  - On a grant with an aligned address (addr[1:0]==0): mem_en=1 and mem_addr=addr[31:2] in the same cycle.
  - On a grant with a misaligned address: mem_en=0. The request is still accepted and err=1 is registered.
- Owner register: at each clock edge, owner becomes IF, LS or NONE according to the grant. The err flag is registered alongside it.
- Response, one cycle after the grant (latency 1):
  - The owner's rsp_valid=1.
  - rsp_data = mem_rdata, or 0 when err=1.
  - rsp_err = the registered err flag.
  - The non-owner's rsp_valid, rsp_err and rsp_data are 0.
- Throughput: one grant per cycle, fully pipelined, back-to-back with no bubbles.
- if_flush:
  - When high in the cycle an IF response is presented, if_rsp_valid is forced to 0 and the response is discarded.
  - A new IF grant in that same cycle proceeds normally.
  - if_flush has no effect on LS responses.
- Simultaneous events: an IF grant and a flush of the previous IF response in the same cycle are independent. Only the old response is suppressed.

Test Plan:
- Reset state: assert rst mid-cycle with no clock edge -> all outputs 0 immediately. After release with no requests -> no rsp_valid for 5 cycles.
- Single IF request: if_req_addr=0x0000_0010, memory word[4]=0xDEAD_BEEF -> cycle 0: if_req_ready=1, mem_en=1, mem_addr=4. Cycle 1: if_rsp_valid=1, if_rsp_data=0xDEAD_BEEF, ls_rsp_valid=0.
- Contention and anti-starvation: both valid continuously with STARVE_MAX=4 -> grant sequence LS,LS,LS,LS,IF,LS,LS,LS,LS,IF... Each response goes to the correct owner one cycle later.
- Misaligned: ls_req_addr=0x0000_0006 -> ls_req_ready=1 and mem_en=0. Next cycle: ls_rsp_valid=1, ls_rsp_err=1, ls_rsp_data=0.
- Flush: IF granted at cycle 0 and if_flush=1 at cycle 1 -> if_rsp_valid=0 at cycle 1. A second IF grant at cycle 1 responds normally at cycle 2.
- Reset mid-operation: LS granted at cycle 0 and rst pulsed before the cycle-1 edge -> no ls_rsp_valid after release, and the starvation counter restarts at 0.

Source files
------------

// File: rtl/imem_read_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the instruction memory.
// The slave view belongs to the arbiter; the master view drives requests and memory data.
interface imem_read_arbiter_if;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_flush;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        if_rsp_err;
    logic        ls_req_valid;
    logic [31:0] ls_req_addr;
    logic        ls_req_ready;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_data;
    logic        ls_rsp_err;
    logic        mem_en;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req_valid, if_req_addr, if_flush,
        input  ls_req_valid, ls_req_addr,
        input  mem_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
        output mem_en, mem_addr
    );

    modport master (
        output if_req_valid, if_req_addr, if_flush,
        output ls_req_valid, ls_req_addr,
        output mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
        input  mem_en, mem_addr
    );
endinterface

// File: rtl/imem_read_arbiter.sv
// Shares the instruction-memory read port between fetch and the LSU.
// LSU has priority; fetch is forced through after STARVE_MAX denied cycles.
module imem_read_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input logic               clk,
    input logic               rst,
    imem_read_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    owner_e           owner_q, owner_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        starved;
    logic        grant_if;
    logic        grant_ls;
    logic        granted;
    logic [31:0] req_addr;
    logic        misal;
    logic [31:0] rsp_data;

    // Grant decision and memory issue; everything is held low during reset.
    always_comb begin
        starved  = (cnt_q == CNT_MAX);
        grant_if = ~rst & bus.if_req_valid
                 & (~bus.ls_req_valid | starved);
        grant_ls = ~rst & bus.ls_req_valid & ~grant_if;
        granted  = grant_if | grant_ls;
        req_addr = grant_if ? bus.if_req_addr : bus.ls_req_addr;
        misal    = |req_addr[1:0];

        bus.if_req_ready = grant_if;
        bus.ls_req_ready = grant_ls;
        bus.mem_en       = granted & ~misal;
        bus.mem_addr     = (granted & ~misal) ? req_addr[31:2] : '0;
    end

    // Next owner, error flag and starvation count.
    always_comb begin
        owner_d = OWN_NONE;
        if (grant_if) begin
            owner_d = OWN_IF;
        end else if (grant_ls) begin
            owner_d = OWN_LS;
        end
        err_d = granted & misal;

        cnt_d = cnt_q;
        if (~bus.if_req_valid | grant_if) begin
            cnt_d = '0;
        end else if (~starved) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Response tracking; reset drops any response still owed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_NONE;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Route the late read data to its owner; flush only kills fetch.
    always_comb begin
        rsp_data = err_q ? 32'h0 : bus.mem_rdata;

        bus.if_rsp_valid = (owner_q == OWN_IF) & ~bus.if_flush;
        bus.if_rsp_err   = bus.if_rsp_valid & err_q;
        bus.if_rsp_data  = bus.if_rsp_valid ? rsp_data : 32'h0;

        bus.ls_rsp_valid = (owner_q == OWN_LS);
        bus.ls_rsp_err   = bus.ls_rsp_valid & err_q;
        bus.ls_rsp_data  = bus.ls_rsp_valid ? rsp_data : 32'h0;
    end

endmodule

// File: tb/tb_imem_read_arbiter.sv
// Directed bench for imem_read_arbiter with a small synchronous memory model.
// Inputs change on the falling edge and are checked 1ns later.
module tb_imem_read_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] mem [0:63];

    imem_read_arbiter_if bus ();

    imem_read_arbiter #(
        .STARVE_MAX(4),
        .CNT_W     (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous read memory: data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            bus.mem_rdata <= mem[bus.mem_addr[5:0]];
        end
    end

    task automatic drive(input logic iv, input logic [31:0] ia,
                         input logic lv, input logic [31:0] la,
                         input logic fl);
        @(negedge clk);
        bus.if_req_valid = iv;
        bus.if_req_addr  = ia;
        bus.ls_req_valid = lv;
        bus.ls_req_addr  = la;
        bus.if_flush     = fl;
        #1;
    endtask

    task automatic test_reset;
        logic [134:0] all_out;
        drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        drive(1'b1, 32'h14, 1'b0, 32'h0, 1'b0);
        checks++;
        if (bus.if_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_ready got %b exp 1", bus.if_req_ready);
        end
        drive(1'b1, 32'h18, 1'b1, 32'h20, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        all_out = {bus.if_req_ready, bus.ls_req_ready, bus.mem_en,
                   bus.mem_addr, bus.if_rsp_valid, bus.if_rsp_err,
                   bus.if_rsp_data, bus.ls_rsp_valid, bus.ls_rsp_err,
                   bus.ls_rsp_data};
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", all_out);
        end
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.if_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold_rsp got %b exp 0", bus.if_rsp_valid);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            checks++;
            if ({bus.if_rsp_valid, bus.ls_rsp_valid} !== 2'b00) begin
                errors++;
                $display("FAIL idle_rsp_%0d got %b exp 00", i,
                         {bus.if_rsp_valid, bus.ls_rsp_valid});
            end
        end
    endtask

    task automatic test_single_if;
        drive(1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({bus.if_req_ready, bus.ls_req_ready, bus.mem_en} !== 3'b101) begin
            errors++;
            $display("FAIL single_grant got %b exp 101",
                     {bus.if_req_ready, bus.ls_req_ready, bus.mem_en});
        end
        checks++;
        if (bus.mem_addr !== 30'd4) begin
            errors++;
            $display("FAIL single_addr got %h exp 4", bus.mem_addr);
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({bus.if_rsp_valid, bus.if_rsp_err, bus.ls_rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL single_rsp_flags got %b exp 100",
                     {bus.if_rsp_valid, bus.if_rsp_err, bus.ls_rsp_valid});
        end
        checks++;
        if (bus.if_rsp_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_data got %h exp deadbeef", bus.if_rsp_data);
        end
    endtask

    task automatic test_contention;
        int prev;
        logic exp_if;
        prev = 0;
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 32'h0000_0020, 1'b1, 32'h0000_0044, 1'b0);
            exp_if = (k % 5 == 4);
            checks++;
            if ({bus.if_req_ready, bus.ls_req_ready} !== {exp_if, ~exp_if}) begin
                errors++;
                $display("FAIL cont_grant_%0d got %b exp %b", k,
                         {bus.if_req_ready, bus.ls_req_ready},
                         {exp_if, ~exp_if});
            end
            checks++;
            if (bus.mem_addr !== (exp_if ? 30'd8 : 30'd17)) begin
                errors++;
                $display("FAIL cont_addr_%0d got %h exp %h", k, bus.mem_addr,
                         exp_if ? 30'd8 : 30'd17);
            end
            checks++;
            if (prev == 0) begin
                if ({bus.if_rsp_valid, bus.ls_rsp_valid} !== 2'b00) begin
                    errors++;
                    $display("FAIL cont_rsp_%0d got %b exp 00", k,
                             {bus.if_rsp_valid, bus.ls_rsp_valid});
                end
            end else if (prev == 1) begin
                if ({bus.if_rsp_valid, bus.ls_rsp_valid, bus.if_rsp_data}
                    !== {2'b10, 32'h1000_0008}) begin
                    errors++;
                    $display("FAIL cont_rsp_%0d got %b/%h exp 10/10000008", k,
                             {bus.if_rsp_valid, bus.ls_rsp_valid},
                             bus.if_rsp_data);
                end
            end else begin
                if ({bus.if_rsp_valid, bus.ls_rsp_valid, bus.ls_rsp_data}
                    !== {2'b01, 32'h1000_0011}) begin
                    errors++;
                    $display("FAIL cont_rsp_%0d got %b/%h exp 01/10000011", k,
                             {bus.if_rsp_valid, bus.ls_rsp_valid},
                             bus.ls_rsp_data);
                end
            end
            prev = exp_if ? 1 : 2;
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({bus.ls_rsp_valid, bus.ls_rsp_data} !== {1'b1, 32'h1000_0011}) begin
            errors++;
            $display("FAIL cont_tail got %b/%h exp 1/10000011",
                     bus.ls_rsp_valid, bus.ls_rsp_data);
        end
    endtask

    task automatic test_misaligned;
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0006, 1'b0);
        checks++;
        if ({bus.ls_req_ready, bus.mem_en} !== 2'b10) begin
            errors++;
            $display("FAIL mis_ls_issue got %b exp 10",
                     {bus.ls_req_ready, bus.mem_en});
        end
        drive(1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({bus.ls_rsp_valid, bus.ls_rsp_err, bus.ls_rsp_data, bus.if_rsp_valid}
            !== {2'b11, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL mis_ls_rsp got %b/%b/%h exp 1/1/0",
                     bus.ls_rsp_valid, bus.ls_rsp_err, bus.ls_rsp_data);
        end
        checks++;
        if ({bus.if_req_ready, bus.mem_en} !== 2'b10) begin
            errors++;
            $display("FAIL mis_if_issue got %b exp 10",
                     {bus.if_req_ready, bus.mem_en});
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({bus.if_rsp_valid, bus.if_rsp_err, bus.if_rsp_data}
            !== {2'b11, 32'h0}) begin
            errors++;
            $display("FAIL mis_if_rsp got %b/%b/%h exp 1/1/0",
                     bus.if_rsp_valid, bus.if_rsp_err, bus.if_rsp_data);
        end
    endtask

    task automatic test_flush;
        drive(1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h0000_0014, 1'b0, 32'h0, 1'b1);
        checks++;
        if (bus.if_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_kill got %b exp 0", bus.if_rsp_valid);
        end
        checks++;
        if ({bus.if_req_ready, bus.mem_en, bus.mem_addr} !== {2'b11, 30'd5}) begin
            errors++;
            $display("FAIL flush_new_grant got %b/%h exp 11/5",
                     {bus.if_req_ready, bus.mem_en}, bus.mem_addr);
        end
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0008, 1'b0);
        checks++;
        if ({bus.if_rsp_valid, bus.if_rsp_data} !== {1'b1, 32'h1000_0005}) begin
            errors++;
            $display("FAIL flush_next_rsp got %b/%h exp 1/10000005",
                     bus.if_rsp_valid, bus.if_rsp_data);
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({bus.ls_rsp_valid, bus.ls_rsp_data} !== {1'b1, 32'h1000_0002}) begin
            errors++;
            $display("FAIL flush_ls_kept got %b/%h exp 1/10000002",
                     bus.ls_rsp_valid, bus.ls_rsp_data);
        end
    endtask

    task automatic test_reset_mid;
        logic exp_if;
        drive(1'b1, 32'h0000_0020, 1'b1, 32'h0000_0044, 1'b0);
        drive(1'b1, 32'h0000_0020, 1'b1, 32'h0000_0044, 1'b0);
        drive(1'b1, 32'h0000_0020, 1'b1, 32'h0000_0044, 1'b0);
        checks++;
        if (bus.ls_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_ls_grant got %b exp 1", bus.ls_req_ready);
        end
        #1;
        rst = 1'b1;
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        #1;
        checks++;
        if ({bus.ls_rsp_valid, bus.ls_req_ready, bus.mem_en} !== 3'b000) begin
            errors++;
            $display("FAIL mid_rst_out got %b exp 000",
                     {bus.ls_rsp_valid, bus.ls_req_ready, bus.mem_en});
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (bus.ls_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_dropped got %b exp 0", bus.ls_rsp_valid);
        end
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 32'h0000_0020, 1'b1, 32'h0000_0044, 1'b0);
            exp_if = (k == 4);
            checks++;
            if (bus.if_req_ready !== exp_if) begin
                errors++;
                $display("FAIL mid_starve_%0d got %b exp %b", k,
                         bus.if_req_ready, exp_if);
            end
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h1000_0000 | 32'(i);
        end
        mem[4] = 32'hDEAD_BEEF;
        rst = 1'b1;
        bus.if_req_valid = 1'b0;
        bus.if_req_addr  = 32'h0;
        bus.ls_req_valid = 1'b0;
        bus.ls_req_addr  = 32'h0;
        bus.if_flush     = 1'b0;

        test_reset();
        test_single_if();
        test_contention();
        test_misaligned();
        test_flush();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
